// File: rtl/reg_xfer_sequencer.sv
// reg_xfer_sequencer: command-driven master for an 8-entry register file.
// Expands LDI / MOV / SWAP / CLR commands into register-file read (RD) and
// write (WR) cycles. SWAP runs three moves through scratch register TEMP_REG.
// Optional build macro REG_XFER_CHECK_EN: SWAPs that involve TEMP_REG or
// have src==dst are rejected with done+cmd_err and no register-file strobes.
module reg_xfer_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 3,
    parameter int TEMP_REG   = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [SEL_WIDTH-1:0]  cmd_src,
    input  logic [SEL_WIDTH-1:0]  cmd_dst,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic [SEL_WIDTH-1:0]  rf_sel_out,
    output logic                  rf_oe,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic [SEL_WIDTH-1:0]  rf_sel_in,
    output logic                  rf_we,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  done,
    output logic                  cmd_err
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    localparam logic [1:0] OP_LDI  = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic [SEL_WIDTH-1:0] TEMP_SEL = SEL_WIDTH'(TEMP_REG);

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [SEL_WIDTH-1:0]    src_q, src_d;
    logic [SEL_WIDTH-1:0]    dst_q, dst_d;
    logic [1:0]              step_q, step_d;
    logic [SEL_WIDTH-1:0]    sel_out_q, sel_out_d;
    logic [SEL_WIDTH-1:0]    sel_in_q, sel_in_d;
    // Write-data register; it also serves as the hold register that captures
    // rf_rdata at the end of every RD cycle.
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic                    reject;

    // Rejection rule for the optional SWAP check; constant 0 when disabled.
`ifdef REG_XFER_CHECK_EN
    assign reject = (cmd_op == OP_SWAP) &&
                    ((cmd_src == TEMP_SEL) || (cmd_dst == TEMP_SEL) || (cmd_src == cmd_dst));
`else
    assign reject = 1'b0;
`endif

    // Next-state logic: accept, step sequencing and the values selects/data take.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        step_d    = step_q;
        sel_out_d = sel_out_q;
        sel_in_d  = sel_in_q;
        wdata_d   = wdata_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    src_d  = cmd_src;
                    dst_d  = cmd_dst;
                    step_d = 2'd0;
                    if (reject) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (cmd_op == OP_LDI || cmd_op == OP_CLR) begin
                        state_d  = S_WR;
                        sel_in_d = cmd_dst;
                        wdata_d  = (cmd_op == OP_LDI) ? cmd_imm : '0;
                    end else begin
                        // MOV and SWAP both start by reading the source.
                        state_d   = S_RD;
                        sel_out_d = cmd_src;
                    end
                end
            end
            S_RD: begin
                state_d = S_WR;
                wdata_d = rf_rdata;
                if (op_q == OP_MOV) begin
                    sel_in_d = dst_q;
                end else begin
                    // SWAP write targets per step: TEMP, src, dst.
                    case (step_q)
                        2'd0:    sel_in_d = TEMP_SEL;
                        2'd1:    sel_in_d = src_q;
                        default: sel_in_d = dst_q;
                    endcase
                end
            end
            S_WR: begin
                if (op_q == OP_SWAP && step_q != 2'd2) begin
                    // SWAP read sources for steps 1 and 2: dst, then TEMP.
                    step_d    = step_q + 2'd1;
                    state_d   = S_RD;
                    sel_out_d = (step_q == 2'd0) ? dst_q : TEMP_SEL;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= 2'b00;
            src_q     <= '0;
            dst_q     <= '0;
            step_q    <= 2'd0;
            sel_out_q <= '0;
            sel_in_q  <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            step_q    <= step_d;
            sel_out_q <= sel_out_d;
            sel_in_q  <= sel_in_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign rf_oe      = (state_q == S_RD);
    assign rf_we      = (state_q == S_WR);
    assign done       = (state_q == S_DONE);
    assign rf_sel_out = sel_out_q;
    assign rf_sel_in  = sel_in_q;
    assign rf_wdata   = wdata_q;
    assign cmd_err    = err_q;

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// Testbench for reg_xfer_sequencer: behavioural register file, command-level
// reference model, directed table, reset-abort sequence and random commands.
module tb_reg_xfer_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_src, cmd_dst;
    logic [7:0] cmd_imm;
    logic [2:0] rf_sel_out, rf_sel_in;
    logic       rf_oe, rf_we;
    logic [7:0] rf_rdata, rf_wdata;
    logic       done, cmd_err;

    int total = 0;
    int bad   = 0;

    // Behavioural register file driven by the DUT, and the model's view.
    logic [7:0] rf  [8];
    logic [7:0] mdl [8];
    logic       rf_clr;

    logic [10:0] exp_w[$], obs_w[$];
    logic [2:0]  exp_r[$], obs_r[$];
    bit          exp_err;

    typedef struct {
        logic [1:0] op;
        logic [2:0] src;
        logic [2:0] dst;
        logic [7:0] imm;
        int         lat;
        int         lat_chk;
    } vec_t;
    vec_t vt[14];

    reg_xfer_sequencer #(.DATA_WIDTH(8), .SEL_WIDTH(3), .TEMP_REG(7)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .rf_sel_out(rf_sel_out), .rf_oe(rf_oe), .rf_rdata(rf_rdata),
        .rf_sel_in(rf_sel_in), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .done(done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (rf_we) begin
            rf[rf_sel_in] <= rf_wdata;
        end
    end

    assign rf_rdata = rf_oe ? rf[rf_sel_out] : 8'h00;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_reject(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst);
`ifdef REG_XFER_CHECK_EN
        return (op == 2'b10) && (src == 3'd7 || dst == 3'd7 || src == dst);
`else
        return 1'b0;
`endif
    endfunction

    // One register move as the file sees it: read s, write d with that value.
    task automatic mv(input logic [2:0] s, input logic [2:0] d);
        exp_r.push_back(s);
        exp_w.push_back({d, mdl[s]});
        mdl[d] = mdl[s];
    endtask

    // Command-level reference: expected reads, writes, error and new contents.
    task automatic model_cmd(input logic [1:0] op, input logic [2:0] src,
                             input logic [2:0] dst, input logic [7:0] imm);
        exp_w.delete();
        exp_r.delete();
        exp_err = 1'b0;
        case (op)
            2'b00: begin exp_w.push_back({dst, imm}); mdl[dst] = imm; end
            2'b11: begin exp_w.push_back({dst, 8'h00}); mdl[dst] = 8'h00; end
            2'b01: mv(src, dst);
            default: begin
                if (is_reject(op, src, dst)) exp_err = 1'b1;
                else begin mv(src, 3'd7); mv(dst, src); mv(3'd7, dst); end
            end
        endcase
    endtask

    function automatic int lat_of(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst);
        if (op == 2'b00 || op == 2'b11) return 2;
        if (op == 2'b01) return 3;
        return is_reject(op, src, dst) ? 1 : 7;
    endfunction

    function automatic logic [63:0] pack_rf();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = rf[i];
        return v;
    endfunction

    function automatic logic [63:0] pack_mdl();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = mdl[i];
        return v;
    endfunction

    // Issue one command, hold cmd_valid high with junk fields while busy,
    // observe every strobe, then compare against the model.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] src,
                           input logic [2:0] dst, input logic [7:0] imm, input int exp_lat);
        int  wait_cnt = 0;
        int  lat = -1;
        bit  overlap = 1'b0;
        bit  busy_rdy = 1'b0;
        bit  err_seen = 1'b0;
        model_cmd(op, src, dst, imm);
        obs_w.delete();
        obs_r.delete();
        @(negedge clk);
        while (!cmd_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk({tag, "_ready_wait"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            cmd_op = 2'($urandom); cmd_src = 3'($urandom);
            cmd_dst = 3'($urandom); cmd_imm = 8'($urandom);
            if (rf_oe && rf_we) overlap = 1'b1;
            if (rf_oe) obs_r.push_back(rf_sel_out);
            if (rf_we) obs_w.push_back({rf_sel_in, rf_wdata});
            if (cmd_ready) busy_rdy = 1'b1;
            if (done) begin
                lat = c;
                err_seen = cmd_err;
                break;
            end
            if (cmd_err) err_seen = 1'b1;
        end
        chk({tag, "_done_cycle"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_cmd_err"}, 64'(err_seen), 64'(exp_err));
        chk({tag, "_busy_ready"}, 64'(busy_rdy), 64'd0);
        chk({tag, "_oe_we_overlap"}, 64'(overlap), 64'd0);
        chk({tag, "_nwrites"}, 64'(obs_w.size()), 64'(exp_w.size()));
        chk({tag, "_nreads"}, 64'(obs_r.size()), 64'(exp_r.size()));
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
            chk($sformatf("%s_write%0d", tag, i), 64'(obs_w[i]), 64'(exp_w[i]));
        for (int i = 0; i < exp_r.size() && i < obs_r.size(); i++)
            chk($sformatf("%s_read%0d", tag, i), 64'(obs_r[i]), 64'(exp_r[i]));
        @(negedge clk);
        chk({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_regfile"}, pack_rf(), pack_mdl());
        cmd_valid = 1'b0;
    endtask

    initial begin
        vt[0]  = '{2'b00, 3'd0, 3'd2, 8'hA5, 2, 2};
        vt[1]  = '{2'b00, 3'd0, 3'd3, 8'h3C, 2, 2};
        vt[2]  = '{2'b01, 3'd3, 3'd5, 8'h00, 3, 3};
        vt[3]  = '{2'b00, 3'd0, 3'd0, 8'h11, 2, 2};
        vt[4]  = '{2'b00, 3'd0, 3'd1, 8'h22, 2, 2};
        vt[5]  = '{2'b10, 3'd0, 3'd1, 8'h00, 7, 7};
        vt[6]  = '{2'b11, 3'd0, 3'd2, 8'h99, 2, 2};
        vt[7]  = '{2'b01, 3'd4, 3'd4, 8'h00, 3, 3};
        vt[8]  = '{2'b10, 3'd6, 3'd6, 8'h00, 7, 1};
        vt[9]  = '{2'b10, 3'd7, 3'd2, 8'h00, 7, 1};
        vt[10] = '{2'b10, 3'd2, 3'd7, 8'h00, 7, 1};
        vt[11] = '{2'b00, 3'd0, 3'd7, 8'hFF, 2, 2};
        vt[12] = '{2'b11, 3'd0, 3'd0, 8'h00, 2, 2};
        vt[13] = '{2'b01, 3'd7, 3'd6, 8'h00, 3, 3};

        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        reset_n = 1'b0; rf_clr = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src = 3'd0; cmd_dst = 3'd0; cmd_imm = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            64'({cmd_ready, rf_oe, rf_we, done, cmd_err, rf_sel_in, rf_sel_out, rf_wdata}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00}));
        reset_n = 1'b1; rf_clr = 1'b0;

        // Directed table.
        for (int i = 0; i < 14; i++) begin
`ifdef REG_XFER_CHECK_EN
            run_cmd($sformatf("vec%0d", i), vt[i].op, vt[i].src, vt[i].dst, vt[i].imm, vt[i].lat_chk);
`else
            run_cmd($sformatf("vec%0d", i), vt[i].op, vt[i].src, vt[i].dst, vt[i].imm, vt[i].lat);
`endif
        end

        // Reset during SWAP step WR(src): abort with no further strobes or done.
        run_cmd("pre4", 2'b00, 3'd0, 3'd4, 8'h44, 2);
        run_cmd("pre5", 2'b00, 3'd0, 3'd5, 8'h55, 2);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_src = 3'd4; cmd_dst = 3'd5; cmd_imm = 8'h00;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        chk("abort_in_wr_src", 64'({rf_we, rf_sel_in}), 64'({1'b1, 3'd4}));
        reset_n = 1'b0;
        #1;
        chk("abort_outputs",
            64'({cmd_ready, rf_oe, rf_we, done, cmd_err, rf_sel_in, rf_sel_out, rf_wdata}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00}));
        mdl[7] = mdl[4];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_quiet", 64'({done, rf_we, rf_oe}), 64'd0);
        end
        reset_n = 1'b1;
        run_cmd("post_abort", 2'b01, 3'd5, 3'd3, 8'h00, 3);

        // Random commands against the model.
        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            logic [2:0] s, d;
            logic [7:0] im;
            op = 2'($urandom); s = 3'($urandom); d = 3'($urandom); im = 8'($urandom);
            run_cmd($sformatf("rnd%0d", i), op, s, d, im, lat_of(op, s, d));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
